// File: rtl/dpram_arb.sv
// Two-requester arbiter in front of a simple dual-port RAM.
// Writes go to port A, reads to port B; each port is arbitrated on its own
// with a round-robin priority bit, so one read and one write from different
// requesters can both be granted in the same cycle. Grants are combinational.
// Read data comes straight from the RAM, which has a 1-cycle registered read.
module dpram_arb #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,

    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dina,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_doutb
);

    // Round-robin state: index of the requester favoured on the next conflict.
    logic          wr_pri;
    logic          rd_pri;
    // One bit per requester: a read was granted last cycle.
    logic [1:0]    rvalid_q;
    // Last granted read address; port B holds it between grants.
    logic [AW-1:0] addrb_q;

    logic [1:0]    wr_req;
    logic [1:0]    rd_req;
    logic [1:0]    wr_gnt;
    logic [1:0]    rd_gnt;

    assign wr_req = {r1_req &  r1_we, r0_req &  r0_we};
    assign rd_req = {r1_req & ~r1_we, r0_req & ~r0_we};

    // Write-port arbitration: sole requester wins, wr_pri breaks ties.
    always_comb begin
        wr_gnt = 2'b00;
        if (!rst) begin
            unique case (wr_req)
                2'b01:   wr_gnt = 2'b01;
                2'b10:   wr_gnt = 2'b10;
                2'b11:   wr_gnt = wr_pri ? 2'b10 : 2'b01;
                default: wr_gnt = 2'b00;
            endcase
        end
    end

    // Read-port arbitration: sole requester wins, rd_pri breaks ties.
    always_comb begin
        rd_gnt = 2'b00;
        if (!rst) begin
            unique case (rd_req)
                2'b01:   rd_gnt = 2'b01;
                2'b10:   rd_gnt = 2'b10;
                2'b11:   rd_gnt = rd_pri ? 2'b10 : 2'b01;
                default: rd_gnt = 2'b00;
            endcase
        end
    end

    // A requester issues either a read or a write, so at most one grant bit is set per side.
    assign r0_gnt = wr_gnt[0] | rd_gnt[0];
    assign r1_gnt = wr_gnt[1] | rd_gnt[1];

    // Port A mux: driven only during a write grant, zero otherwise.
    always_comb begin
        ram_wea   = 1'b0;
        ram_addra = '0;
        ram_dina  = '0;
        if (wr_gnt[0]) begin
            ram_wea   = 1'b1;
            ram_addra = r0_addr;
            ram_dina  = r0_wdata;
        end else if (wr_gnt[1]) begin
            ram_wea   = 1'b1;
            ram_addra = r1_addr;
            ram_dina  = r1_wdata;
        end
    end

    // Port B mux: new address on a read grant, otherwise hold the last one.
    always_comb begin
        ram_addrb = addrb_q;
        if (rd_gnt[0])
            ram_addrb = r0_addr;
        else if (rd_gnt[1])
            ram_addrb = r1_addr;
    end

    // Priority, read-valid pipeline and held port-B address.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pri   <= 1'b0;
            rd_pri   <= 1'b0;
            rvalid_q <= 2'b00;
            addrb_q  <= '0;
        end else begin
            // After a grant the loser (the other index) is favoured next time.
            if (|wr_gnt) wr_pri <= wr_gnt[0];
            if (|rd_gnt) rd_pri <= rd_gnt[0];
            rvalid_q <= rd_gnt;
            addrb_q  <= ram_addrb;
        end
    end

    // Masking with rst drops a read granted just before reset asserted.
    assign r0_rvalid = rvalid_q[0] & ~rst;
    assign r1_rvalid = rvalid_q[1] & ~rst;
    assign r0_rdata  = ram_doutb;
    assign r1_rdata  = ram_doutb;

endmodule

// File: tb/tb_dpram_arb.sv
// Bench for dpram_arb: a read-first RAM model is attached to the RAM ports,
// grants are checked inline per scenario, and read data is checked by a
// scoreboard fed at grant time and drained when rvalid is due.
module tb_dpram_arb;
    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          r0_req = 1'b0, r0_we = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r1_req = 1'b0, r1_we = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          ram_wea;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dina;
    logic [DW-1:0] ram_doutb = '0;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit            id;
        logic [DW-1:0] data;
    } rd_t;
    rd_t exp_q[$];
    rd_t e;

    logic [DW-1:0] ram   [0:(1<<AW)-1];
    logic [DW-1:0] model [0:(1<<AW)-1];

    always #5 clk = ~clk;

    dpram_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
    );

    // Read-first simple dual-port RAM with registered output.
    always @(posedge clk) begin
        if (ram_wea) ram[ram_addra] <= ram_dina;
        ram_doutb <= ram[ram_addrb];
    end

    // Scoreboard drain: each expected read must show up the cycle after its grant.
    always @(posedge clk) begin
        #3;
        if (mon_en) begin
            checks++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.id == 1'b0) begin
                    if (r0_rvalid !== 1'b1 || r1_rvalid !== 1'b0 || r0_rdata !== e.data) begin
                        errors++;
                        $display("FAIL sb_r0: got rv0=%b rv1=%b data=%h, want rv0=1 rv1=0 data=%h",
                                 r0_rvalid, r1_rvalid, r0_rdata, e.data);
                    end
                end else begin
                    if (r1_rvalid !== 1'b1 || r0_rvalid !== 1'b0 || r1_rdata !== e.data) begin
                        errors++;
                        $display("FAIL sb_r1: got rv0=%b rv1=%b data=%h, want rv0=0 rv1=1 data=%h",
                                 r0_rvalid, r1_rvalid, r1_rdata, e.data);
                    end
                end
            end else if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL sb_idle: got rv0=%b rv1=%b, want 0 0", r0_rvalid, r1_rvalid);
            end
        end
    end

    task automatic drive(input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 1, 10'd4, 16'hDEAD, 1, 0, 10'd9, 16'h0);
        @(negedge clk);
        checks++;
        if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || ram_wea !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got g0=%b g1=%b wea=%b, want 0 0 0", r0_gnt, r1_gnt, ram_wea);
        end
        @(posedge clk); #1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0 || ram_addrb !== '0 || ram_addra !== '0) begin
            errors++;
            $display("FAIL reset_state: got rv0=%b rv1=%b addrb=%h addra=%h, want 0 0 0 0",
                     r0_rvalid, r1_rvalid, ram_addrb, ram_addra);
        end
        checks++;
        if (ram[4] !== 16'h0) begin
            errors++;
            $display("FAIL reset_nowrite: got mem4=%h, want 0", ram[4]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_write_read();
        do_reset();
        @(posedge clk); #1;
        drive(1, 1, 10'd3, 16'hA5A5, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0 || ram_wea !== 1'b1 || ram_addra !== 10'd3 || ram_dina !== 16'hA5A5) begin
            errors++;
            $display("FAIL wr_single: got g0=%b g1=%b wea=%b addra=%h dina=%h, want 1 0 1 003 a5a5",
                     r0_gnt, r1_gnt, ram_wea, ram_addra, ram_dina);
        end
        model[3] = 16'hA5A5;
        @(posedge clk); #1;
        drive(1, 0, 10'd3, '0, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (r0_gnt !== 1'b1 || ram_addrb !== 10'd3 || ram_wea !== 1'b0 || ram_addra !== '0 || ram_dina !== '0) begin
            errors++;
            $display("FAIL rd_single: got g0=%b addrb=%h wea=%b addra=%h dina=%h, want 1 003 0 000 0000",
                     r0_gnt, ram_addrb, ram_wea, ram_addra, ram_dina);
        end
        exp_q.push_back('{1'b0, model[3]});
        @(posedge clk); #1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (ram_addrb !== 10'd3 || r1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL addrb_hold: got addrb=%h rv1=%b, want 003 0", ram_addrb, r1_rvalid);
        end
    endtask

    task automatic test_write_conflict();
        logic [1:0] w_exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drive(1, 1, 10'd1, 16'h0001, 1, 1, 10'd2, 16'h0002);
            @(negedge clk);
            w_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({r1_gnt, r0_gnt} !== w_exp || ram_wea !== 1'b1 ||
                ram_addra !== (w_exp[0] ? 10'd1 : 10'd2) || ram_dina !== (w_exp[0] ? 16'h0001 : 16'h0002)) begin
                errors++;
                $display("FAIL wr_conflict_%0d: got gnt=%b wea=%b addra=%h dina=%h, want gnt=%b wea=1",
                         i, {r1_gnt, r0_gnt}, ram_wea, ram_addra, ram_dina, w_exp);
            end
            if (w_exp[0]) model[1] = 16'h0001; else model[2] = 16'h0002;
        end
        @(posedge clk); #1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_rw_same_addr();
        do_reset();
        @(posedge clk); #1;
        drive(1, 1, 10'd5, 16'h1111, 0, 0, '0, '0);
        @(negedge clk);
        model[5] = 16'h1111;
        @(posedge clk); #1;
        drive(1, 1, 10'd5, 16'h2222, 1, 0, 10'd5, '0);
        @(negedge clk);
        checks++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b1 || ram_addrb !== 10'd5 || ram_addra !== 10'd5) begin
            errors++;
            $display("FAIL rw_both: got g0=%b g1=%b addrb=%h addra=%h, want 1 1 005 005",
                     r0_gnt, r1_gnt, ram_addrb, ram_addra);
        end
        exp_q.push_back('{1'b1, model[5]});
        model[5] = 16'h2222;
        @(posedge clk); #1;
        drive(0, 0, '0, '0, 1, 0, 10'd5, '0);
        @(negedge clk);
        checks++;
        if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rw_reread: got g0=%b g1=%b, want 0 1", r0_gnt, r1_gnt);
        end
        exp_q.push_back('{1'b1, model[5]});
        @(posedge clk); #1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_read_conflict();
        bit w;
        do_reset();
        @(posedge clk); #1;
        drive(1, 1, 10'd7, 16'h0777, 0, 0, '0, '0);
        @(negedge clk);
        model[7] = 16'h0777;
        @(posedge clk); #1;
        drive(0, 0, '0, '0, 1, 1, 10'd8, 16'h0888);
        @(negedge clk);
        model[8] = 16'h0888;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(1, 0, 10'd7, '0, 1, 0, 10'd8, '0);
            @(negedge clk);
            w = (i % 2 != 0);
            checks++;
            if ({r1_gnt, r0_gnt} !== (w ? 2'b10 : 2'b01) || ram_addrb !== (w ? 10'd8 : 10'd7)) begin
                errors++;
                $display("FAIL rd_conflict_%0d: got gnt=%b addrb=%h, want winner r%0d",
                         i, {r1_gnt, r0_gnt}, ram_addrb, w);
            end
            exp_q.push_back('{w, w ? model[8] : model[7]});
        end
        @(posedge clk); #1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            drive(1, 0, 10'(i), '0, 0, 0, '0, '0);
            @(negedge clk);
            checks++;
            if (r0_gnt !== 1'b1 || ram_addrb !== 10'(i)) begin
                errors++;
                $display("FAIL b2b_%0d: got g0=%b addrb=%h, want 1 %h", i, r0_gnt, ram_addrb, 10'(i));
            end
            exp_q.push_back('{1'b0, model[i]});
        end
        @(posedge clk); #1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_reset_cancel();
        do_reset();
        // Contested write moves wr_pri to r1, so the post-reset grant proves the reset.
        @(posedge clk); #1;
        drive(1, 1, 10'd20, 16'h0020, 1, 1, 10'd21, 16'h0021);
        @(negedge clk);
        model[20] = 16'h0020;
        @(posedge clk); #1;
        drive(0, 0, '0, '0, 1, 0, 10'd8, '0);
        @(negedge clk);
        checks++;
        if (r1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL cancel_gnt: got g1=%b, want 1", r1_gnt);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        checks++;
        if (r1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cancel_rv: got rv1=%b, want 0", r1_rvalid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (r1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cancel_rv_after: got rv1=%b, want 0", r1_rvalid);
        end
        @(posedge clk); #1;
        drive(1, 1, 10'd22, 16'h0022, 1, 1, 10'd23, 16'h0023);
        @(negedge clk);
        checks++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0 || ram_addra !== 10'd22) begin
            errors++;
            $display("FAIL cancel_wrpri: got g0=%b g1=%b addra=%h, want 1 0 016", r0_gnt, r1_gnt, ram_addra);
        end
        model[22] = 16'h0022;
        @(posedge clk); #1;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]   = '0;
            model[i] = '0;
        end
        test_reset();
        test_write_read();
        test_write_conflict();
        test_rw_same_addr();
        test_read_conflict();
        test_back_to_back();
        test_reset_cancel();
        repeat (3) @(posedge clk);
        #4;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending reads, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
